oht2bin_pipe: RTL and testbench

//  Pipelined one-hot to binary encoder with valid/ready stream handshake and one-hot error detection.

---
 rtl/oht2bin_pkg.sv | 60 ++++++
 rtl/oht2bin_pipe_node.sv | 50 +++++
 rtl/oht2bin_pipe.sv | 141 ++++++++++++++
 tb/tb_oht2bin_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oht2bin_pkg.sv
// Shared sizing helpers and result types for the pipelined one-hot encoder.
package oht2bin_pkg;

  // Number of SPLIT-ary tree levels needed to cover width inputs.
  function automatic int levels(input int width, input int split);
    int p;
    int n;
    p = 1;
    n = 0;
    while (p < width) begin
      p = p * split;
      n++;
    end
    return n;
  endfunction

  // Width of the full tree index: log2 of the padded input width.
  function automatic int power_log(input int width, input int split);
    return levels(width, split) * $clog2(split);
  endfunction

  // Number of node results sitting on tree boundaries 0..b-1.
  // Boundary 0 is the leaf vector, boundary levels() is the root.
  function automatic int nodes_off(input int width, input int split, input int b);
    int cnt;
    int off;
    cnt = split ** levels(width, split);
    off = 0;
    for (int j = 0; j < b; j++) begin
      off = off + cnt;
      cnt = cnt / split;
    end
    return off;
  endfunction

  // Bit offset of boundary b inside the packed partial-index bus.
  function automatic int bin_off(input int width, input int split, input int b);
    int cnt;
    int off;
    cnt = split ** levels(width, split);
    off = 0;
    for (int j = 0; j < b; j++) begin
      off = off + cnt * j * $clog2(split);
      cnt = cnt / split;
    end
    return off;
  endfunction

  // Physical port width for a child index that may be empty (leaves).
  function automatic int cbw_phys(input int cbw);
    return (cbw == 0) ? 1 : cbw;
  endfunction

  // Flag part of a node result; the index part varies in width per level.
  typedef struct packed {
    logic any;
    logic err;
  } flags_t;

endpackage

// File: rtl/oht2bin_pipe_node.sv
// One SPLIT-ary combinational tree node: merges child {any, err, bin} results.
module oht2bin_pipe_node
  import oht2bin_pkg::*;
#(
  parameter int SPLIT = 2,
  parameter int CBW   = 0
) (
  input  logic [SPLIT-1:0]                  c_any,
  input  logic [SPLIT-1:0]                  c_err,
  input  logic [SPLIT*cbw_phys(CBW)-1:0]    c_bin,
  output logic                              any,
  output logic                              err,
  output logic [$clog2(SPLIT)+CBW-1:0]      bin
);

  localparam int SB   = $clog2(SPLIT);
  localparam int CBWP = cbw_phys(CBW);

  logic [SB-1:0]   hi;
  logic [CBWP-1:0] lo;
  logic            seen;
  logic            multi;

  // OR-merge child indices and detect more than one active child.
  always_comb begin
    hi    = '0;
    lo    = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int c = 0; c < SPLIT; c++) begin
      if (c_any[c]) hi = hi | SB'(c);
      lo    = lo | c_bin[c*CBWP +: CBWP];
      multi = multi | (seen & c_any[c]);
      seen  = seen | c_any[c];
    end
  end

  assign any = |c_any;
  assign err = (|c_err) | multi;

  if (CBW == 0) begin : g_leaf
    // Leaves carry no index; the one-bit child bus is tied off and unused.
    logic unused_lo;
    assign unused_lo = ^lo;
    assign bin       = hi;
  end else begin : g_inner
    assign bin = {hi, lo};
  end

endmodule

// File: rtl/oht2bin_pipe.sv
// Pipelined one-hot to binary encoder: SPLIT-ary OR tree with optional
// register slice after each level and a valid/ready stream handshake.
module oht2bin_pipe
  import oht2bin_pkg::*;
#(
  parameter int                                WIDTH   = 32,
  parameter int                                SPLIT   = 2,
  parameter logic [levels(WIDTH, SPLIT)-1:0]   REGMASK = '1,
  localparam int                               WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [WIDTH-1:0]     i_oht,
  output logic                 o_vld,
  input  logic                 o_rdy,
  output logic [WIDTH_LOG-1:0] o_bin,
  output logic                 o_any,
  output logic                 o_err
);

  localparam int LEVELS    = levels(WIDTH, SPLIT);
  localparam int SB        = $clog2(SPLIT);
  localparam int POWER     = SPLIT ** LEVELS;
  localparam int POWER_LOG = power_log(WIDTH, SPLIT);
  localparam int ANY_TOT   = nodes_off(WIDTH, SPLIT, LEVELS + 1);
  localparam int BIN_TOT   = bin_off(WIDTH, SPLIT, LEVELS + 1);
  localparam int AF        = nodes_off(WIDTH, SPLIT, LEVELS);
  localparam int BF        = bin_off(WIDTH, SPLIT, LEVELS);

  if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("oht2bin_pipe: SPLIT must be a power of 2 and at least 2");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("oht2bin_pipe: WIDTH must be at least 2");
  end

  // Node results for every tree boundary, leaves first, root last.
  logic [ANY_TOT-1:0] any_bus;
  logic [ANY_TOT-1:0] err_bus;
  logic [BIN_TOT-1:0] bin_bus;
  // Handshake chain: vld_c[l]/rdy_c[l] sit at the input of level l.
  logic [LEVELS:0]    vld_c;
  logic [LEVELS:0]    rdy_c;
  flags_t             fin;

  // Padding bits above WIDTH are constant zero, so they never flag.
  assign any_bus[0 +: POWER] = POWER'(i_oht);
  assign err_bus[0 +: POWER] = '0;
  assign vld_c[0]            = i_vld;
  assign i_rdy               = rdy_c[0];
  assign rdy_c[LEVELS]       = o_rdy;
  assign o_vld               = vld_c[LEVELS];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int CIN  = SPLIT ** (LEVELS - l);
    localparam int NOUT = CIN / SPLIT;
    localparam int CBW  = l * SB;
    localparam int CBWP = cbw_phys(CBW);
    localparam int OBW  = CBW + SB;
    localparam int AI   = nodes_off(WIDTH, SPLIT, l);
    localparam int AO   = nodes_off(WIDTH, SPLIT, l + 1);
    localparam int BI   = bin_off(WIDTH, SPLIT, l);
    localparam int BO   = bin_off(WIDTH, SPLIT, l + 1);

    logic [CIN*CBWP-1:0] in_bin;
    logic [NOUT-1:0]     n_any;
    logic [NOUT-1:0]     n_err;
    logic [NOUT*OBW-1:0] n_bin;

    if (l == 0) begin : g_zero
      assign in_bin = '0;
    end else begin : g_tap
      assign in_bin = bin_bus[BI +: CIN*CBW];
    end

    for (genvar n = 0; n < NOUT; n++) begin : g_node
      oht2bin_pipe_node #(
        .SPLIT (SPLIT),
        .CBW   (CBW)
      ) u_node (
        .c_any (any_bus[AI + n*SPLIT +: SPLIT]),
        .c_err (err_bus[AI + n*SPLIT +: SPLIT]),
        .c_bin (in_bin[n*SPLIT*CBWP +: SPLIT*CBWP]),
        .any   (n_any[n]),
        .err   (n_err[n]),
        .bin   (n_bin[n*OBW +: OBW])
      );
    end

    if (REGMASK[l]) begin : g_reg
      logic                vld_p;
      logic [NOUT-1:0]     any_p;
      logic [NOUT-1:0]     err_p;
      logic [NOUT*OBW-1:0] bin_p;

      // Register slice: load when empty or draining; payload only on valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= 1'b0;
          any_p <= '0;
          err_p <= '0;
          bin_p <= '0;
        end else if (!vld_p || rdy_c[l+1]) begin
          vld_p <= vld_c[l];
          if (vld_c[l]) begin
            any_p <= n_any;
            err_p <= n_err;
            bin_p <= n_bin;
          end
        end
      end

      assign any_bus[AO +: NOUT]     = any_p;
      assign err_bus[AO +: NOUT]     = err_p;
      assign bin_bus[BO +: NOUT*OBW] = bin_p;
      assign vld_c[l+1]              = vld_p;
      assign rdy_c[l]                = !vld_p || rdy_c[l+1];
    end else begin : g_comb
      assign any_bus[AO +: NOUT]     = n_any;
      assign err_bus[AO +: NOUT]     = n_err;
      assign bin_bus[BO +: NOUT*OBW] = n_bin;
      assign vld_c[l+1]              = vld_c[l];
      assign rdy_c[l]                = rdy_c[l+1];
    end
  end

  // Root of the tree drives the output payload.
  assign fin   = '{any: any_bus[AF], err: err_bus[AF]};
  assign o_any = fin.any;
  assign o_err = fin.err;
  assign o_bin = bin_bus[BF +: WIDTH_LOG];

  if (POWER_LOG > WIDTH_LOG) begin : g_trunc
    // Index bits above WIDTH_LOG can only come from padding and are dropped.
    logic unused_bin_hi;
    assign unused_bin_hi = ^bin_bus[BF + WIDTH_LOG +: POWER_LOG - WIDTH_LOG];
  end

endmodule

// File: tb/tb_oht2bin_pipe.sv
// Self-checking bench for oht2bin_pipe: table vectors, scoreboard, corner cases.
module tb_oht2bin_pipe;

  typedef struct packed {
    logic [31:0] oht;
    logic [4:0]  bin;
    logic        any;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [4:0]  bin;
    logic        any;
    logic        err;
    logic [31:0] t_in;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cyc = '0;

  // DUT A: WIDTH=32, SPLIT=2, all levels registered (L=5)
  logic        a_ivld, a_irdy, a_ovld, a_any, a_err;
  logic        a_ordy = 1'b1;
  logic [31:0] a_oht;
  logic [4:0]  a_bin;
  // DUT B: WIDTH=20, SPLIT=4, REGMASK=3'b101 (L=2)
  logic        b_ivld, b_irdy, b_ovld, b_ordy, b_any, b_err;
  logic [19:0] b_oht;
  logic [4:0]  b_bin;
  // DUT C: WIDTH=32, SPLIT=2, REGMASK=0 (combinational)
  logic        c_ivld, c_irdy, c_ovld, c_ordy, c_any, c_err;
  logic [31:0] c_oht;
  logic [4:0]  c_bin;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;   // 0: o_rdy high, 1: random, 2: low
  bit   lat_chk  = 1'b0;
  vec_t a_exp;
  sb_t  a_q[$];
  vec_t tbl [37];

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2), .REGMASK(5'b11111)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_vld(a_ivld), .i_rdy(a_irdy), .i_oht(a_oht),
    .o_vld(a_ovld), .o_rdy(a_ordy), .o_bin(a_bin), .o_any(a_any), .o_err(a_err));

  oht2bin_pipe #(.WIDTH(20), .SPLIT(4), .REGMASK(3'b101)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_vld(b_ivld), .i_rdy(b_irdy), .i_oht(b_oht),
    .o_vld(b_ovld), .o_rdy(b_ordy), .o_bin(b_bin), .o_any(b_any), .o_err(b_err));

  oht2bin_pipe #(.WIDTH(32), .SPLIT(2), .REGMASK(5'b00000)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_vld(c_ivld), .i_rdy(c_irdy), .i_oht(c_oht),
    .o_vld(c_ovld), .o_rdy(c_ordy), .o_bin(c_bin), .o_any(c_any), .o_err(c_err));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-ready driver for DUT A
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       a_ordy = ($urandom_range(1) == 1);
      2:       a_ordy = 1'b0;
      default: a_ordy = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t model(input logic [31:0] v);
    vec_t r;
    int   c;
    c     = 0;
    r.oht = v;
    r.bin = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        r.bin = r.bin | 5'(i);
        c++;
      end
    end
    r.any = (c > 0);
    r.err = (c > 1);
    return r;
  endfunction

  // Scoreboard monitor for DUT A, sampled mid-cycle
  logic       prev_stall = 1'b0;
  logic [6:0] prev_pl    = '0;
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_hold_vld", {31'd0, a_ovld}, 32'd1);
        check("stall_hold_payload", {25'd0, a_bin, a_any, a_err}, {25'd0, prev_pl});
      end
      if (a_ivld && a_irdy)
        a_q.push_back('{bin: a_exp.bin, any: a_exp.any, err: a_exp.err, t_in: cyc + 1});
      if (a_ovld && a_ordy) begin
        if (a_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: bin=%0d any=%0b err=%0b with empty scoreboard",
                   a_bin, a_any, a_err);
        end else begin
          e = a_q.pop_front();
          check("out_payload", {25'd0, a_bin, a_any, a_err}, {25'd0, e.bin, e.any, e.err});
          if (lat_chk) check("latency", cyc + 1 - e.t_in, 32'd5);
        end
      end
      prev_stall = a_ovld && !a_ordy;
      prev_pl    = {a_bin, a_any, a_err};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_a(input vec_t v);
    int w;
    w      = 0;
    a_exp  = v;
    a_oht  = v.oht;
    a_ivld = 1'b1;
    forever begin
      @(negedge clk);
      if (a_irdy) break;
      w++;
      if (w > 300) begin
        n_chk++;
        $display("FAIL send_timeout: i_rdy stuck low for %0d cycles", w);
        break;
      end
    end
    @(posedge clk);
    #1;
    a_ivld = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((a_q.size() != 0 || a_ovld) && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (a_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries expected 0", a_q.size());
  endtask

  task automatic b_one(input logic [19:0] v, input logic [4:0] eb, input logic ea, input logic ee);
    @(posedge clk);
    #1;
    b_ivld = 1'b1;
    b_oht  = v;
    @(negedge clk);
    check("b_irdy", {31'd0, b_irdy}, 32'd1);
    @(posedge clk);
    #1;
    b_ivld = 1'b0;
    @(negedge clk);
    check("b_vld_early", {31'd0, b_ovld}, 32'd0);
    @(negedge clk);
    check("b_vld_lat2", {31'd0, b_ovld}, 32'd1);
    check("b_payload", {25'd0, b_bin, b_any, b_err}, {25'd0, eb, ea, ee});
    @(negedge clk);
    check("b_vld_after", {31'd0, b_ovld}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int n = 0; n < 32; n++)
      tbl[n] = '{oht: 32'd1 << n, bin: 5'(n), any: 1'b1, err: 1'b0};
    tbl[32] = '{oht: 32'h0000_0000, bin: 5'd0,  any: 1'b0, err: 1'b0};
    tbl[33] = '{oht: 32'h0000_0041, bin: 5'd6,  any: 1'b1, err: 1'b1};
    tbl[34] = '{oht: 32'h8000_0001, bin: 5'd31, any: 1'b1, err: 1'b1};
    tbl[35] = '{oht: 32'h0000_0003, bin: 5'd1,  any: 1'b1, err: 1'b1};
    tbl[36] = '{oht: 32'h0000_0300, bin: 5'd9,  any: 1'b1, err: 1'b1};

    rst_n  = 1'b0;
    a_ivld = 1'b0; a_oht = '0; a_exp = '0;
    b_ivld = 1'b0; b_oht = '0; b_ordy = 1'b1;
    c_ivld = 1'b0; c_oht = '0; c_ordy = 1'b0;

    // Reset and idle
    #12;
    check("rst_a_vld", {31'd0, a_ovld}, 32'd0);
    check("rst_a_bin", {27'd0, a_bin}, 32'd0);
    check("rst_a_flags", {30'd0, a_any, a_err}, 32'd0);
    check("rst_a_irdy", {31'd0, a_irdy}, 32'd1);
    check("rst_b_vld", {31'd0, b_ovld}, 32'd0);
    check("rst_b_irdy", {31'd0, b_irdy}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_a_vld", {31'd0, a_ovld}, 32'd0);
    check("idle_a_bin", {27'd0, a_bin}, 32'd0);
    check("idle_a_irdy", {31'd0, a_irdy}, 32'd1);

    // Combinational instance against the vector table
    for (int i = 0; i < 37; i++) begin
      c_oht  = tbl[i].oht;
      c_ivld = 1'b1;
      c_ordy = i[0];
      #1;
      check("c_bin", {27'd0, c_bin}, {27'd0, tbl[i].bin});
      check("c_flags", {30'd0, c_any, c_err}, {30'd0, tbl[i].any, tbl[i].err});
      check("c_vld", {31'd0, c_ovld}, 32'd1);
      check("c_irdy", {31'd0, c_irdy}, {31'd0, i[0]});
    end
    c_ivld = 1'b0;
    #1;
    check("c_vld_low", {31'd0, c_ovld}, 32'd0);

    // Back-to-back sweep with fixed latency, then zero and multi-hot
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    for (int i = 0; i < 37; i++) send_a(tbl[i]);
    wait_drain();
    lat_chk = 1'b0;

    // Random backpressure and random input gaps
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] v;
      case ($urandom_range(7))
        0:       v = 32'd0;
        1:       v = (32'd1 << $urandom_range(31)) | (32'd1 << $urandom_range(31));
        default: v = 32'd1 << $urandom_range(31);
      endcase
      if ($urandom_range(2) == 0) begin
        @(posedge clk);
        #1;
      end
      send_a(model(v));
    end
    rdy_mode = 0;
    wait_drain();

    // Non-power-of-split width with partial register mask
    b_one(20'h8_0000, 5'd19, 1'b1, 1'b0);
    b_one(20'h8_0008, 5'd19, 1'b1, 1'b1);
    b_one(20'h0_0400, 5'd10, 1'b1, 1'b0);
    b_one(20'h0_0000, 5'd0,  1'b0, 1'b0);

    // Fill DUT A with output stalled, then reset between edges
    rdy_mode = 2;
    @(posedge clk);
    #2;
    for (int i = 3; i < 8; i++) send_a(tbl[i]);
    check("full_a_vld", {31'd0, a_ovld}, 32'd1);
    check("full_a_irdy", {31'd0, a_irdy}, 32'd0);
    #2;
    rst_n = 1'b0;
    c_oht = 32'h0000_1000; c_ivld = 1'b1; c_ordy = 1'b0;
    #1;
    a_q.delete();
    check("midrst_a_vld", {31'd0, a_ovld}, 32'd0);
    check("midrst_a_payload", {25'd0, a_bin, a_any, a_err}, 32'd0);
    check("midrst_a_irdy", {31'd0, a_irdy}, 32'd1);
    check("midrst_c_vld", {31'd0, c_ovld}, 32'd1);
    check("midrst_c_irdy", {31'd0, c_irdy}, 32'd0);
    check("midrst_c_bin", {27'd0, c_bin}, 32'd12);
    c_ivld = 1'b0;
    @(posedge clk);
    #3;
    rst_n    = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_stale_vld", {31'd0, a_ovld}, 32'd0);
    end

    // Normal traffic resumes after reset
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send_a(tbl[9]);
    send_a(tbl[33]);
    wait_drain();
    lat_chk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
